bg_tile_fetcher: RTL

BG_TILE_FETCHER -- requirements
Module: bg_tile_fetcher

---
 rtl/bg_tile_fetcher.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bg_tile_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : bg_tile_fetcher
// Purpose  : Fetches one background tile (nametable, attribute, two pattern
//            planes) from VRAM and feeds 16-bit pixel shifters.
// Option   : BG_ATTR_FETCH_EN adds the attribute fetch, latch and shifters.
// Revision : 1.0 - initial release
// ============================================================================
module bg_tile_fetcher (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tile_start,
  input  logic [15:0] nt_addr,
  input  logic [15:0] attr_addr,
  input  logic [1:0]  attr_sel,
  input  logic [2:0]  fine_y,
  input  logic [2:0]  fine_x,
  input  logic        reload,
  input  logic        shift_en,
  output logic [3:0]  dec_tile_row,
  output logic [3:0]  dec_tile_col,
  output logic        dec_bit_plane,
  output logic [2:0]  dec_y_offset,
  input  logic [15:0] dec_addr,
  output logic        vram_req,
  output logic [15:0] vram_addr,
  input  logic        vram_ack,
  input  logic [7:0]  vram_rdata,
  output logic        busy,
  output logic        tile_ready,
  output logic [1:0]  pixel_out,
  output logic [1:0]  attr_out
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_nt    = 3'd1;
`ifdef BG_ATTR_FETCH_EN
  localparam logic [2:0] c_at    = 3'd2;
`endif
  localparam logic [2:0] c_pt_lo = 3'd3;
  localparam logic [2:0] c_pt_hi = 3'd4;
  localparam logic [2:0] c_done  = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        w_fire;
  logic [7:0]  r_tile_idx;
  logic [2:0]  r_fine_y;
  logic [7:0]  r_pt_lo;
  logic [7:0]  r_pt_hi;
  logic [7:0]  r_latch_lo;
  logic [7:0]  r_latch_hi;
  logic        r_tile_ready;
  logic [15:0] r_lo_sr;
  logic [15:0] r_hi_sr;
  logic [3:0]  w_pix_idx;

  assign w_fire        = vram_req && vram_ack;
  assign w_pix_idx     = 4'd15 - {1'b0, fine_x};
  assign busy          = (r_state != c_idle);
  assign tile_ready    = r_tile_ready;
  assign dec_tile_row  = r_tile_idx[7:4];
  assign dec_tile_col  = r_tile_idx[3:0];
  assign dec_bit_plane = (r_state == c_pt_hi);
  assign dec_y_offset  = r_fine_y;
  assign pixel_out     = {r_hi_sr[w_pix_idx], r_lo_sr[w_pix_idx]};

  always_comb begin
    vram_req  = 1'b0;
    vram_addr = 16'h0000;
    case (r_state)
      c_nt:    begin vram_req = 1'b1; vram_addr = nt_addr;  end
`ifdef BG_ATTR_FETCH_EN
      c_at:    begin vram_req = 1'b1; vram_addr = attr_addr; end
`endif
      c_pt_lo: begin vram_req = 1'b1; vram_addr = dec_addr; end
      c_pt_hi: begin vram_req = 1'b1; vram_addr = dec_addr; end
      default: begin vram_req = 1'b0; vram_addr = 16'h0000; end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (tile_start) w_next_state = c_nt;
`ifdef BG_ATTR_FETCH_EN
      c_nt:    if (w_fire) w_next_state = c_at;
      c_at:    if (w_fire) w_next_state = c_pt_lo;
`else
      c_nt:    if (w_fire) w_next_state = c_pt_lo;
`endif
      c_pt_lo: if (w_fire) w_next_state = c_pt_hi;
      c_pt_hi: if (w_fire) w_next_state = c_done;
      c_done:  w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_idle;
      r_tile_ready <= 1'b0;
      r_tile_idx   <= 8'h00;
      r_fine_y     <= 3'd0;
      r_pt_lo      <= 8'h00;
      r_pt_hi      <= 8'h00;
      r_latch_lo   <= 8'h00;
      r_latch_hi   <= 8'h00;
    end else begin
      r_state      <= w_next_state;
      r_tile_ready <= (r_state == c_done);
      if (r_state == c_idle && tile_start) r_fine_y <= fine_y;
      if (r_state == c_nt && w_fire)      r_tile_idx <= vram_rdata;
      if (r_state == c_pt_lo && w_fire)   r_pt_lo <= vram_rdata;
      if (r_state == c_pt_hi && w_fire)   r_pt_hi <= vram_rdata;
      if (r_state == c_done) begin
        r_latch_lo <= r_pt_lo;
        r_latch_hi <= r_pt_hi;
      end
    end
  end

  // Reload with shift loads the latch one position below its usual slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo_sr <= 16'h0000;
      r_hi_sr <= 16'h0000;
    end else if (reload && shift_en) begin
      r_lo_sr <= {r_lo_sr[14:7], r_latch_lo};
      r_hi_sr <= {r_hi_sr[14:7], r_latch_hi};
    end else if (reload) begin
      r_lo_sr <= {r_lo_sr[15:8], r_latch_lo};
      r_hi_sr <= {r_hi_sr[15:8], r_latch_hi};
    end else if (shift_en) begin
      r_lo_sr <= {r_lo_sr[14:0], 1'b0};
      r_hi_sr <= {r_hi_sr[14:0], 1'b0};
    end
  end

`ifdef BG_ATTR_FETCH_EN
  logic [1:0]  r_attr;
  logic [1:0]  r_latch_attr;
  logic [1:0]  w_attr_bits;
  logic [15:0] r_at_lo_sr;
  logic [15:0] r_at_hi_sr;

  always_comb begin
    case (attr_sel)
      2'd0:    w_attr_bits = vram_rdata[1:0];
      2'd1:    w_attr_bits = vram_rdata[3:2];
      2'd2:    w_attr_bits = vram_rdata[5:4];
      default: w_attr_bits = vram_rdata[7:6];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_attr       <= 2'b00;
      r_latch_attr <= 2'b00;
    end else begin
      if (r_state == c_at && w_fire) r_attr <= w_attr_bits;
      if (r_state == c_done)         r_latch_attr <= r_attr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_at_lo_sr <= 16'h0000;
      r_at_hi_sr <= 16'h0000;
    end else if (reload && shift_en) begin
      r_at_lo_sr <= {r_at_lo_sr[14:7], {8{r_latch_attr[0]}}};
      r_at_hi_sr <= {r_at_hi_sr[14:7], {8{r_latch_attr[1]}}};
    end else if (reload) begin
      r_at_lo_sr <= {r_at_lo_sr[15:8], {8{r_latch_attr[0]}}};
      r_at_hi_sr <= {r_at_hi_sr[15:8], {8{r_latch_attr[1]}}};
    end else if (shift_en) begin
      r_at_lo_sr <= {r_at_lo_sr[14:0], 1'b0};
      r_at_hi_sr <= {r_at_hi_sr[14:0], 1'b0};
    end
  end

  assign attr_out = {r_at_hi_sr[w_pix_idx], r_at_lo_sr[w_pix_idx]};
`else
  logic w_unused_attr;
  assign w_unused_attr = ^{attr_addr, attr_sel};
  assign attr_out      = 2'b00;
`endif

endmodule
`default_nettype wire
